// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between MEM stage and word-wide Data_memory; resp latency: fault/SW 1, load 2, SB/SH 3.
// One request in flight: req_ready only in IDLE; the response pulse has no back-pressure.
module lsu_mem_ctrl #(
  parameter int address_width = 10,
  parameter int data_width    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [data_width-1:0] resp_rdata,
  output logic [1:0]            resp_fault,
  output logic [31:0]           address,
  output logic [data_width-1:0] write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [data_width-1:0] read_data
);

  typedef enum logic [2:0] {
    IDLE, FAULT, LD_RD, LD_RESP, RMW_RD, RMW_MERGE, ST_WR
  } state_e;

  localparam logic [1:0] F_NONE    = 2'd0;
  localparam logic [1:0] F_MISAL   = 2'd1;
  localparam logic [1:0] F_RANGE   = 2'd2;
  localparam logic [1:0] F_ILLEGAL = 2'd3;

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [31:0]           addr_q, addr_d;
  logic [data_width-1:0] word_q, word_d;
  logic [1:0]            fault_q, fault_d;

  logic                  accept;
  logic                  out_of_range;
  logic [1:0]            req_fault;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [data_width-1:0] extracted;
  logic [data_width-1:0] merged;

  assign accept       = req_valid && req_ready;
  assign out_of_range = {1'b0, req_addr} >= (33'd1 << address_width);

  always_comb begin
    req_fault = F_NONE;
    if (req_store ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11))
      req_fault = F_ILLEGAL;
    else if ((req_funct3[1:0] == 2'd1 && req_addr[0]) ||
             (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0))
      req_fault = F_MISAL;
    else if (out_of_range)
      req_fault = F_RANGE;
  end

  assign ld_byte = read_data[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = read_data[{addr_q[1], 4'b0000} +: 16];

  // funct3[2] set means LBU/LHU: no sign extension
  always_comb begin
    extracted = '0;
    case (funct3_q[1:0])
      2'd0:    extracted = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
      2'd1:    extracted = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
      default: extracted = read_data;
    endcase
  end

  always_comb begin
    merged = read_data;
    if (funct3_q[1:0] == 2'd0)
      merged[{addr_q[1:0], 3'b000} +: 8] = word_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = word_q[15:0];
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    word_d   = word_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          word_d   = req_wdata;
          fault_d  = req_fault;
          if (req_fault != F_NONE)          state_d = FAULT;
          else if (!req_store)              state_d = LD_RD;
          else if (req_funct3[1:0] == 2'd2) state_d = ST_WR;
          else                              state_d = RMW_RD;
        end
      end
      FAULT:     state_d = IDLE;
      LD_RD:     state_d = LD_RESP;
      LD_RESP:   state_d = IDLE;
      RMW_RD:    state_d = RMW_MERGE;
      RMW_MERGE: begin
        word_d  = merged;
        state_d = ST_WR;
      end
      ST_WR:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      word_q   <= '0;
      fault_q  <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      word_q   <= word_d;
      fault_q  <= fault_d;
    end
  end

  // Strobes and response are gated by rst so an abort mid-operation never writes or responds
  assign req_ready  = (state_q == IDLE);
  assign mem_read   = !rst && (state_q == LD_RD || state_q == RMW_RD);
  assign mem_write  = !rst && (state_q == ST_WR);
  assign resp_valid = !rst && (state_q inside {FAULT, LD_RESP, ST_WR});
  assign resp_fault = (resp_valid && state_q == FAULT) ? fault_q : F_NONE;
  assign resp_rdata = (resp_valid && state_q == LD_RESP) ? extracted : '0;
  assign address    = {addr_q[31:2], 2'b00};
  assign write_data = word_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, reset-abort sequences, then random traffic vs a word-array model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;

  lsu_mem_ctrl #(.address_width(10), .data_width(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .address(address), .write_data(write_data), .mem_write(mem_write),
    .mem_read(mem_read), .read_data(read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  bit          preload = 1'b1;

  // Data_memory stand-in: synchronous read, write on strobe
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else begin
      if (mem_write) mem[address[9:2]] <= write_data;
      if (mem_read)  read_data <= mem[address[9:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed semantics on a word array
  task automatic model(input bit st, input bit [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [1:0] flt, output logic [31:0] rd, output int lat,
                       output int nrd, output int nwr);
    int          size;
    bit          illegal;
    logic [31:0] w;
    logic [31:0] v;
    size    = 1 << f3[1:0];
    illegal = st ? (f3 > 2) : (f3 == 3 || f3 > 5);
    rd = 0; nrd = 0; nwr = 0; lat = 1;
    if (illegal)                 flt = 3;
    else if (a % size != 0)      flt = 1;
    else if (a >= 32'd1024)      flt = 2;
    else                         flt = 0;
    if (flt != 0) return;
    w = ref_mem[a / 4];
    if (!st) begin
      v = w >> (8 * (a % 4));
      if (size == 1)      rd = (f3 < 4 && v[7])  ? (v | 32'hFFFFFF00) : (v & 32'h000000FF);
      else if (size == 2) rd = (f3 < 4 && v[15]) ? (v | 32'hFFFF0000) : (v & 32'h0000FFFF);
      else                rd = v;
      lat = 2; nrd = 1;
    end else begin
      for (int i = 0; i < size; i++) w[8 * ((a % 4) + i) +: 8] = wd[8 * i +: 8];
      ref_mem[a / 4] = w;
      lat = (size == 4) ? 1 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end
  endtask

  // Issues one request from a negedge; returns at the negedge where resp_valid was seen
  task automatic do_req(input bit st, input bit [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input bit noise, output logic [1:0] flt, output logic [31:0] rd,
                        output int lat, output int nrd, output int nwr);
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready before issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    flt = 0; rd = 0; lat = 0; nrd = 0; nwr = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (noise && lat == 1) begin
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h34; req_wdata = 32'h11111111;
      end
      if (noise && lat == 2) req_valid = 1'b0;
      if (resp_valid) begin
        flt = resp_fault;
        rd  = resp_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    bit          st;
    bit [2:0]    f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  flt;
    logic [31:0] rd;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit st, bit [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [1:0] flt, logic [31:0] rd, int lat, int nrd, int nwr);
    vec_t v;
    v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.flt = flt; v.rd = rd;
    v.lat = lat; v.nrd = nrd; v.nwr = nwr;
    return v;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic reset_abort(input string name, input bit [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int cycles_before_rst);
    logic [31:0] pre;
    bit          wr_seen = 0;
    bit          rv_seen = 0;
    wait_idle();
    pre = mem[a[9:2]];
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < cycles_before_rst; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    wr_seen |= mem_write;
    rv_seen |= resp_valid;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wr_seen |= mem_write;
      rv_seen |= resp_valid;
    end
    rst = 1'b0;
    @(negedge clk);
    chk({name, " req_ready after rst"}, {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_seen |= mem_write;
      rv_seen |= resp_valid;
    end
    chk({name, " mem_write seen"}, {31'd0, wr_seen}, 32'd0);
    chk({name, " resp_valid seen"}, {31'd0, rv_seen}, 32'd0);
    chk({name, " word unchanged"}, mem[a[9:2]], pre);
  endtask

  initial begin
    logic [1:0]  flt, mflt;
    logic [31:0] rd, mrd;
    int          lat, nrd, nwr, mlat, mnrd, mnwr;
    int          bad;

    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;

    @(negedge clk);
    preload = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("reset resp_rdata", resp_rdata, 32'd0);
      chk("reset resp_fault", {30'd0, resp_fault}, 32'd0);
      chk("reset address", address, 32'd0);
      chk("reset write_data", write_data, 32'd0);
      chk("reset strobes", {30'd0, mem_read, mem_write}, 32'd0);
      if (c == 0) @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready after reset", {31'd0, req_ready}, 32'd1);

    vt.push_back(mk(1, 2, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1, 0, 1));
    vt.push_back(mk(0, 2, 32'h10,  32'h0,        0, 32'hDEADBEEF, 2, 1, 0));
    vt.push_back(mk(1, 0, 32'h13,  32'h000000A5, 0, 32'h0,        3, 1, 1));
    vt.push_back(mk(0, 2, 32'h10,  32'h0,        0, 32'hA5ADBEEF, 2, 1, 0));
    vt.push_back(mk(0, 0, 32'h13,  32'h0,        0, 32'hFFFFFFA5, 2, 1, 0));
    vt.push_back(mk(0, 4, 32'h13,  32'h0,        0, 32'h000000A5, 2, 1, 0));
    vt.push_back(mk(1, 1, 32'h12,  32'h00001234, 0, 32'h0,        3, 1, 1));
    vt.push_back(mk(0, 1, 32'h12,  32'h0,        0, 32'h00001234, 2, 1, 0));
    vt.push_back(mk(0, 2, 32'h10,  32'h0,        0, 32'h1234BEEF, 2, 1, 0));
    vt.push_back(mk(0, 1, 32'h11,  32'h0,        1, 32'h0,        1, 0, 0));
    vt.push_back(mk(0, 2, 32'h400, 32'h0,        2, 32'h0,        1, 0, 0));
    vt.push_back(mk(0, 3, 32'h400, 32'h0,        3, 32'h0,        1, 0, 0));
    vt.push_back(mk(1, 2, 32'h3FC, 32'h8001FF7F, 0, 32'h0,        1, 0, 1));
    vt.push_back(mk(0, 2, 32'h3FC, 32'h0,        0, 32'h8001FF7F, 2, 1, 0));
    vt.push_back(mk(0, 1, 32'h3FE, 32'h0,        0, 32'hFFFF8001, 2, 1, 0));
    vt.push_back(mk(0, 5, 32'h3FE, 32'h0,        0, 32'h00008001, 2, 1, 0));
    vt.push_back(mk(0, 0, 32'h3FD, 32'h0,        0, 32'hFFFFFFFF, 2, 1, 0));
    vt.push_back(mk(0, 4, 32'h3FC, 32'h0,        0, 32'h0000007F, 2, 1, 0));
    vt.push_back(mk(0, 1, 32'h3FC, 32'h0,        0, 32'hFFFFFF7F, 2, 1, 0));
    vt.push_back(mk(1, 3, 32'h10,  32'h0,        3, 32'h0,        1, 0, 0));
    vt.push_back(mk(1, 1, 32'h401, 32'h0,        1, 32'h0,        1, 0, 0));
    vt.push_back(mk(1, 2, 32'h3FE, 32'h0,        1, 32'h0,        1, 0, 0));
    vt.push_back(mk(0, 2, 32'hFFFFFFFC, 32'h0,   2, 32'h0,        1, 0, 0));
    vt.push_back(mk(0, 6, 32'h11,  32'h0,        3, 32'h0,        1, 0, 0));
    vt.push_back(mk(1, 0, 32'h3FF, 32'h12345699, 0, 32'h0,        3, 1, 1));
    vt.push_back(mk(0, 2, 32'h3FC, 32'h0,        0, 32'h9901FF7F, 2, 1, 0));
    vt.push_back(mk(0, 0, 32'h3FF, 32'h0,        0, 32'hFFFFFF99, 2, 1, 0));

    foreach (vt[i]) begin
      do_req(vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, vt[i].st && vt[i].f3 < 2,
             flt, rd, lat, nrd, nwr);
      model(vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, mflt, mrd, mlat, mnrd, mnwr);
      chk($sformatf("vec%0d fault", i), {30'd0, flt}, {30'd0, vt[i].flt});
      chk($sformatf("vec%0d rdata", i), rd, vt[i].rd);
      chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d mem_read pulses", i), nrd, vt[i].nrd);
      chk($sformatf("vec%0d mem_write pulses", i), nwr, vt[i].nwr);
    end

    reset_abort("rst in RMW_MERGE", 3'd0, 32'h20, 32'h000000CC, 2);
    reset_abort("rst in ST_WR", 3'd2, 32'h24, 32'h77777777, 1);

    for (int n = 0; n < 300; n++) begin
      bit          st;
      bit [2:0]    f3;
      logic [31:0] a;
      logic [31:0] wd;
      st = 1'($urandom);
      f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom);
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(1016, 1031));
        default: a = 32'($urandom_range(0, 1023));
      endcase
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      wd = $urandom;
      do_req(st, f3, a, wd, st && f3 < 2 && n[0], flt, rd, lat, nrd, nwr);
      model(st, f3, a, wd, mflt, mrd, mlat, mnrd, mnwr);
      chk($sformatf("rnd%0d fault", n), {30'd0, flt}, {30'd0, mflt});
      chk($sformatf("rnd%0d rdata", n), rd, mrd);
      chk($sformatf("rnd%0d latency", n), lat, mlat);
      chk($sformatf("rnd%0d strobes", n), {nrd[15:0], nwr[15:0]}, {mnrd[15:0], mnwr[15:0]});
    end

    @(negedge clk);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("memory image words differing", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
